// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and the index-to-one-hot helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [N-1:0] decode_idx(input logic [IDX_W-1:0] idx);
        logic [N-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
    import rr_arb_pkg::*;

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    // rot[k] is the request k positions after ptr; index arithmetic wraps naturally in IDX_W bits
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[ptr + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign found = |rot;
    assign idx   = ptr + off;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a one-cycle turnaround gap and bounded tenure.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_reg,     state_next;
    logic [IDX_W-1:0]  ptr_reg,       ptr_next;
    logic [IDX_W-1:0]  gnt_idx_reg,   gnt_idx_next;
    logic [N-1:0]      gnt_reg,       gnt_next;
    logic              gnt_valid_reg, gnt_valid_next;
    logic [HOLD_W-1:0] hold_cnt_reg,  hold_cnt_next;
    logic              preempt_reg,   preempt_next;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              others_pending;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign others_pending = |(bus.req & ~decode_idx(gnt_idx_reg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            hold_cnt_reg  <= '0;
            preempt_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
            hold_cnt_reg  <= hold_cnt_next;
            preempt_reg   <= preempt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        gnt_idx_next   = gnt_idx_reg;
        gnt_next       = gnt_reg;
        gnt_valid_next = gnt_valid_reg;
        hold_cnt_next  = hold_cnt_reg;
        preempt_next   = 1'b0;

        case (state_reg)
            IDLE, GAP: begin
                if (pick_found) begin
                    state_next     = GRANT;
                    gnt_idx_next   = pick_idx;
                    gnt_next       = decode_idx(pick_idx);
                    gnt_valid_next = 1'b1;
                    hold_cnt_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end

            GRANT: begin
                // Voluntary release outranks preemption so preempt never fires on a leaving owner
                if (!bus.req[gnt_idx_reg]) begin
                    state_next     = GAP;
                    gnt_next       = '0;
                    gnt_valid_next = 1'b0;
                    ptr_next       = gnt_idx_reg + IDX_W'(1);
                end else if (hold_cnt_reg == HOLD_LAST && others_pending) begin
                    state_next     = GAP;
                    gnt_next       = '0;
                    gnt_valid_next = 1'b0;
                    preempt_next   = 1'b1;
                    ptr_next       = gnt_idx_reg + IDX_W'(1);
                end else if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end

            default: begin
                state_next     = IDLE;
                gnt_next       = '0;
                gnt_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_idx   = gnt_idx_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.preempt   = preempt_reg;

endmodule
